// File: rtl/high_score_keeper_if.sv
// high_score_keeper_if: login, game-result and score-report signals between the access controller and the keeper
interface high_score_keeper_if;
  logic       valid_in;
  logic [2:0] user_ID;
  logic       game_over;
  logic [7:0] game_score;
  logic [7:0] user_high;
  logic [7:0] top_score;
  logic [2:0] top_user;
  logic       new_record;
  logic       busy;
  logic       id_err;
  modport master (
    output valid_in, user_ID, game_over, game_score,
    input  user_high, top_score, top_user, new_record, busy, id_err
  );
  modport slave (
    input  valid_in, user_ID, game_over, game_score,
    output user_high, top_score, top_user, new_record, busy, id_err
  );
endinterface

// File: rtl/high_score_keeper.sv
// high_score_keeper: six-user high-score table with per-user login, record detection and overall leader tracking
module high_score_keeper (
  input logic clk,
  input logic rst,
  high_score_keeper_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, READY, CMP, WRITE} state_t;
  state_t state, state_n;
  logic [7:0] tbl [0:5];
  logic [2:0] cur_id;
  logic [7:0] score_q;
  logic [7:0] user_high_q;
  logic [7:0] top_score_q;
  logic [2:0] top_user_q;
  logic       valid_q;
  logic       id_err_q;
  logic       rise;
  logic       bad_id;
  logic [7:0] best;
  logic [2:0] best_id;
  assign rise = bus.valid_in && !valid_q;
  assign bad_id = bus.user_ID > 3'd5;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (rise && !bad_id) ? LOAD : IDLE;
      LOAD:    state_n = READY;
      READY:   state_n = bus.game_over ? CMP : READY;
      CMP:     state_n = (score_q > user_high_q) ? WRITE : READY;
      WRITE:   state_n = READY;
      default: state_n = IDLE;
    endcase
    if (state != IDLE && !bus.valid_in) state_n = IDLE;
  end
  always_comb begin
    best = '0;
    best_id = '0;
    for (int i = 0; i < 6; i++)
      if (tbl[i] > best) begin
        best = tbl[i];
        best_id = 3'(i);
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      for (int i = 0; i < 6; i++) tbl[i] <= '0;
      cur_id <= '0;
      score_q <= '0;
      user_high_q <= '0;
      top_score_q <= '0;
      top_user_q <= '0;
      valid_q <= 1'b0;
      id_err_q <= 1'b0;
    end else begin
      state <= state_n;
      valid_q <= bus.valid_in;
      id_err_q <= state == IDLE && rise && bad_id;
      if (state == IDLE && rise && !bad_id) cur_id <= bus.user_ID;
      if (state == READY && bus.game_over) score_q <= bus.game_score;
      if (state == WRITE) tbl[cur_id] <= score_q;
      user_high_q <= state_n == IDLE ? 8'd0 : state == LOAD ? tbl[cur_id] : state == WRITE ? score_q : user_high_q;
      top_score_q <= best;
      top_user_q <= best_id;
    end
  end
  assign bus.user_high = user_high_q;
  assign bus.top_score = top_score_q;
  assign bus.top_user = top_user_q;
  assign bus.new_record = state == WRITE;
  assign bus.busy = state == LOAD || state == CMP || state == WRITE;
  assign bus.id_err = id_err_q;
endmodule

// File: doc/high_score_keeper.md
HIGH_SCORE_KEEPER -- requirements
Module: high_score_keeper

Interface
REQ-001 SHALL provide ports: clk  input  1  rising-edge system clock.
REQ-002 SHALL provide ports: rst  input  1  synchronous, active-high reset (one clock; polarity and synchronicity fixed).
REQ-003 SHALL provide ports: valid_in  input  1  login-valid level from the access controller; 1 = a user is logged in.
REQ-004 SHALL provide ports: user_ID  input  3  table address of the logged-in user; legal values 0-5; sampled only on the valid_in rising edge.
REQ-005 SHALL provide ports: game_over  input  1  one-cycle pulse marking the end of a game.
REQ-006 SHALL provide ports: game_score  input  8  unsigned final score; sampled in the same cycle as game_over.
REQ-007 SHALL provide ports: user_high  output  8  stored high score of the current user; 0 when logged out.
REQ-008 SHALL provide ports: top_score  output  8  highest score across all six entries.
REQ-009 SHALL provide ports: top_user  output  3  address of the entry holding top_score.
REQ-010 SHALL provide ports: new_record  output  1  one-cycle pulse when the current user's high score is raised.
REQ-011 SHALL provide ports: busy  output  1  high while in states LOAD, CMP or WRITE.
REQ-012 SHALL provide ports: id_err  output  1  one-cycle pulse on a login attempt with user_ID 6 or 7.

Function
REQ-013 SHALL hold a 6-entry x 8-bit score table in registers, all entries 0 after reset.
REQ-014 SHALL implement states IDLE, LOAD, READY, CMP, WRITE.
REQ-015 IDLE: on valid_in 0->1 with user_ID<=5, SHALL latch user_ID into cur_id and go to LOAD next cycle.
REQ-016 IDLE: on valid_in 0->1 with user_ID>5, SHALL pulse id_err, stay IDLE, and leave the table unchanged.
REQ-017 LOAD: SHALL copy table[cur_id] to user_high, then enter READY; user_high is valid 2 cycles after the valid_in edge.
REQ-018 READY: on game_over=1, SHALL latch game_score and enter CMP; game_over in any other state SHALL be ignored (not queued).
REQ-019 CMP: if latched score > user_high, SHALL enter WRITE; otherwise SHALL return to READY with no table change.
REQ-020 Equal scores SHALL NOT count as a record (strict greater-than).
REQ-021 WRITE: SHALL write table[cur_id] and update user_high, pulse new_record for exactly this cycle, then return to READY; game_over-to-new_record latency is 2 cycles.
REQ-022 top_score/top_user SHALL be recomputed each cycle from the table (registered, one cycle behind table writes).
REQ-023 Ties for top_score SHALL resolve to the lowest address.
REQ-024 valid_in=0 in any non-IDLE state SHALL go to IDLE next cycle and clear user_high to 0.
REQ-025 A valid_in drop while in WRITE SHALL still complete that cycle's table write; a drop in CMP SHALL abort with no write.
REQ-026 user_ID changes while logged in SHALL be ignored; cur_id changes only via a new login.
REQ-027 Scores are unsigned 8-bit with no arithmetic beyond comparison, so overflow cannot occur.

Reset
REQ-028 rst=1 at a clock edge SHALL force state IDLE, all table entries 0, user_high=0, top_score=0, top_user=0, new_record=0, busy=0, id_err=0, cur_id=0.
REQ-029 rst SHALL take priority over all other inputs, including a game_over or WRITE in the same cycle.

Verification
REQ-030 Apply reset, raise valid_in with user_ID=2 -> busy=1 for 1 cycle, user_high=0 two cycles after the edge, top_score=0, top_user=0.
REQ-031 Logged in as 2, game_over with score 45 -> new_record pulses 2 cycles later, user_high=45, top_score=45 and top_user=2 one cycle after that.
REQ-032 With user 2 at 45, game_over with score 45, then 30 -> no new_record pulse, table unchanged; then 46 -> new_record, user_high=46.
REQ-033 Logout, log in as 4, score 46 -> user_high=46, top_user stays 2 (tie, lowest address); log in as 0 -> user_high=0.
REQ-034 Login with user_ID=7 -> id_err pulses 1 cycle, state stays IDLE, and a subsequent game_over is ignored.
REQ-035 Score 99 game_over with valid_in dropping in the CMP cycle -> no write and no new_record; rst asserted mid-READY -> all outputs and table entries back to 0.
